vend_txn_ctrl: RTL and testbench

//  Transaction controller of the vending machine: tracks per-product stock, accepts coins,
//  and computes amount still owed and change. Sits directly upstream of the 7-seg display

---
 rtl/vend_pkg.sv | 27 ++
 rtl/vend_hold_timer.sv | 28 ++
 rtl/vend_txn_ctrl.sv | 158 +++++++++++++++
 tb/tb_vend_txn_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine transaction controller:
// FSM state encoding, product price table, coin values and a saturating add helper.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAY,
        ST_VEND,
        ST_CHANGE,
        ST_REFUND
    } vend_state_t;

    localparam logic [3:0] PRICE [0:3] = '{4'd3, 4'd5, 4'd7, 4'd9};

    localparam logic [4:0] COIN1_VAL = 5'd1;
    localparam logic [4:0] COIN2_VAL = 5'd2;

    // Restock adds at most the free space left, so stock never exceeds cap.
    function automatic logic [3:0] sat_add(input logic [3:0] cur,
                                           input logic [3:0] amt,
                                           input logic [3:0] cap);
        logic [4:0] total;
        total = {1'b0, cur} + {1'b0, amt};
        return (total > {1'b0, cap}) ? cap : total[3:0];
    endfunction

endpackage

// File: rtl/vend_hold_timer.sv
// Loadable down-counter: load has priority, en decrements until zero, done flags zero.
// Used for the CHANGE/REFUND display hold and for the optional PAY timeout.
module vend_hold_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: per-product stock, coin acceptance, change/refund.
// Optional VEND_TIMEOUT_EN: PAY auto-cancels after TIMEOUT_CYC cycles without a coin.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int MAX_STOCK   = 15,
    parameter int HOLD_CYC    = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] prod_sel,
    input  logic       buy_req,
    input  logic       coin_1,
    input  logic       coin_2,
    input  logic       cancel,
    input  logic       restock_req,
    input  logic [3:0] restock_amt,
    output logic [3:0] quant,
    output logic [3:0] max_add,
    output logic [3:0] pay_remain,
    output logic [3:0] back,
    output logic       seg_en,
    output logic       vend_done,
    output logic       busy
);

    localparam logic [3:0] MAX_Q = 4'(MAX_STOCK);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

    vend_state_t state, state_n;
    logic [4:0]  paid, paid_n, sum;
    logic [1:0]  lock, lock_n, sel_n;
    logic [3:0]  stock [4];
    logic [3:0]  stock_n [4];
    logic [3:0]  back_n, quant_n;
    logic        vend_n, hold_load, hold_done, hold_en;
    logic        to_load, timeout, coin_any;

    assign coin_any = coin_1 | coin_2;
    assign sum      = paid + (coin_1 ? COIN1_VAL : 5'd0) + (coin_2 ? COIN2_VAL : 5'd0);
    assign hold_en  = (state == ST_CHANGE) || (state == ST_REFUND);

    vend_hold_timer #(.W(HOLD_W)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .en       (hold_en),
        .done     (hold_done)
    );

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic to_done;

    // Reloaded on PAY entry and every coin; a coin in the expiry cycle still counts.
    vend_hold_timer #(.W(TO_W)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load     (to_load),
        .load_val (TO_W'(TIMEOUT_CYC - 1)),
        .en       (state == ST_PAY),
        .done     (to_done)
    );

    assign timeout = (state == ST_PAY) && to_done && !coin_any;
`else
    logic unused_timeout;
    assign unused_timeout = to_load ^ (TIMEOUT_CYC != 0);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        paid_n    = paid;
        lock_n    = lock;
        back_n    = back;
        vend_n    = 1'b0;
        hold_load = 1'b0;
        to_load   = 1'b0;
        for (int i = 0; i < 4; i++) stock_n[i] = stock[i];

        case (state)
            ST_IDLE: begin
                back_n = '0;
                paid_n = '0;
                if (restock_req) begin
                    stock_n[prod_sel] = sat_add(stock[prod_sel], restock_amt, MAX_Q);
                end else if (buy_req && (stock[prod_sel] != 4'd0)) begin
                    lock_n  = prod_sel;
                    state_n = ST_PAY;
                    to_load = 1'b1;
                end
            end
            ST_PAY: begin
                paid_n  = sum;
                to_load = coin_any;
                // Cancel wins even if this cycle's coins reach the price.
                if (cancel || timeout) begin
                    state_n   = ST_REFUND;
                    back_n    = sum[3:0];
                    hold_load = 1'b1;
                end else if (sum >= {1'b0, PRICE[lock]}) begin
                    state_n = ST_VEND;
                end
            end
            ST_VEND: begin
                stock_n[lock] = stock[lock] - 4'd1;
                vend_n        = 1'b1;
                back_n        = paid[3:0] - PRICE[lock];
                state_n       = ST_CHANGE;
                hold_load     = 1'b1;
            end
            ST_CHANGE, ST_REFUND: begin
                if (hold_done) begin
                    state_n = ST_IDLE;
                    back_n  = '0;
                    paid_n  = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        sel_n   = (state_n == ST_IDLE) ? prod_sel : lock_n;
        quant_n = stock_n[sel_n];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            paid       <= '0;
            lock       <= '0;
            for (int i = 0; i < 4; i++) stock[i] <= MAX_Q;
            quant      <= MAX_Q;
            max_add    <= '0;
            pay_remain <= '0;
            back       <= '0;
            seg_en     <= 1'b0;
            vend_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            paid       <= paid_n;
            lock       <= lock_n;
            for (int i = 0; i < 4; i++) stock[i] <= stock_n[i];
            quant      <= quant_n;
            max_add    <= MAX_Q - quant_n;
            pay_remain <= (state_n == ST_PAY) ? (PRICE[lock_n] - paid_n[3:0]) : 4'd0;
            back       <= back_n;
            seg_en     <= 1'b1;
            vend_done  <= vend_n;
            busy       <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Self-checking bench for vend_txn_ctrl: directed scenarios plus randomized purchases
// checked against a transaction-level stock/payment model. Honours VEND_TIMEOUT_EN.
module tb_vend_txn_ctrl;

    localparam int HOLD = 8;
    localparam int MAXS = 15;
`ifdef VEND_TIMEOUT_EN
    localparam int TO_CYC = 20;
`else
    localparam int TO_CYC = 1000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] prod_sel;
    logic       buy_req, coin_1, coin_2, cancel, restock_req;
    logic [3:0] restock_amt;
    logic [3:0] quant, max_add, pay_remain, back;
    logic       seg_en, vend_done, busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         stock_m [4];
    int         price_m [4] = '{3, 5, 7, 9};
    logic [3:0] exp_q [$];
    int         script_q [$];

    vend_txn_ctrl #(
        .MAX_STOCK   (MAXS),
        .HOLD_CYC    (HOLD),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prod_sel    (prod_sel),
        .buy_req     (buy_req),
        .coin_1      (coin_1),
        .coin_2      (coin_2),
        .cancel      (cancel),
        .restock_req (restock_req),
        .restock_amt (restock_amt),
        .quant       (quant),
        .max_add     (max_add),
        .pay_remain  (pay_remain),
        .back        (back),
        .seg_en      (seg_en),
        .vend_done   (vend_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        buy_req     = 1'b0;
        coin_1      = 1'b0;
        coin_2      = 1'b0;
        cancel      = 1'b0;
        restock_req = 1'b0;
    endtask

    // Expected display during the hold window, with ignored noise on every input pulse.
    task automatic hold_phase(input int eb, input int p, input int is_vend);
        logic [3:0] e;
        for (int i = 0; i < HOLD; i++) exp_q.push_back(4'(eb));
        for (int i = 0; i < HOLD; i++) begin
            e = exp_q.pop_front();
            check("hold_back", int'(back), int'(e));
            check("hold_busy", int'(busy), 1);
            check("hold_vend_done", int'(vend_done), (i == 0) ? is_vend : 0);
            check("hold_remain", int'(pay_remain), 0);
            coin_1      = 1'($urandom_range(0, 1));
            coin_2      = 1'($urandom_range(0, 1));
            cancel      = 1'($urandom_range(0, 1));
            restock_req = 1'($urandom_range(0, 1));
            restock_amt = 4'($urandom_range(0, 15));
            tick();
            clear_pulses();
        end
        check("idle_busy", int'(busy), 0);
        check("idle_back", int'(back), 0);
        check("idle_quant", int'(quant), stock_m[p]);
        check("idle_max_add", int'(max_add), MAXS - stock_m[p]);
    endtask

    task automatic restock(input int p, input int a, input int with_buy);
        prod_sel    = 2'(p);
        restock_amt = 4'(a);
        restock_req = 1'b1;
        buy_req     = 1'(with_buy);
        tick();
        clear_pulses();
        stock_m[p] = (stock_m[p] + a > MAXS) ? MAXS : stock_m[p] + a;
        check("rs_quant", int'(quant), stock_m[p]);
        check("rs_max_add", int'(max_add), MAXS - stock_m[p]);
        check("rs_busy", int'(busy), 0);
    endtask

    // Coin codes: bit0 = coin_1, bit1 = coin_2, +4 = cancel; taken from script_q when set.
    task automatic purchase(input int p, input int allow_cancel);
        int c, cn, code, paid, price;
        price    = price_m[p];
        prod_sel = 2'(p);
        buy_req  = 1'b1;
        tick();
        buy_req = 1'b0;
        if (stock_m[p] == 0) begin
            check("empty_busy", int'(busy), 0);
            check("empty_quant", int'(quant), 0);
            check("empty_remain", int'(pay_remain), 0);
            return;
        end
        check("buy_busy", int'(busy), 1);
        check("buy_remain", int'(pay_remain), price);
        check("buy_quant", int'(quant), stock_m[p]);
        paid = 0;
        for (int k = 0; k < 60; k++) begin
            if (script_q.size() > 0) begin
                code = script_q.pop_front();
                c    = code % 4;
                cn   = code / 4;
            end else begin
                c  = $urandom_range(0, 3);
                cn = (allow_cancel != 0 && $urandom_range(0, 5) == 0) ? 1 : 0;
            end
            coin_1 = c[0];
            coin_2 = c[1];
            cancel = cn[0];
            if ($urandom_range(0, 3) == 0) begin
                buy_req  = 1'b1;
                prod_sel = 2'($urandom_range(0, 3));
            end
            tick();
            clear_pulses();
            prod_sel = 2'(p);
            paid += c;
            if (cn != 0) begin
                check("refund_remain", int'(pay_remain), 0);
                check("refund_quant", int'(quant), stock_m[p]);
                hold_phase(paid, p, 0);
                return;
            end
            if (paid >= price) begin
                check("vend_remain", int'(pay_remain), 0);
                check("vend_done_early", int'(vend_done), 0);
                check("vend_busy", int'(busy), 1);
                tick();
                stock_m[p]--;
                check("vend_quant", int'(quant), stock_m[p]);
                hold_phase(paid - price, p, 1);
                return;
            end
            check("pay_remain", int'(pay_remain), price - paid);
            check("pay_quant", int'(quant), stock_m[p]);
            check("pay_busy", int'(busy), 1);
        end
        check("pay_bound", int'(busy), 0);
    endtask

    initial begin
        clear_pulses();
        restock_amt = 4'd0;
        prod_sel    = 2'd2;
        rst         = 1'b0;
        for (int i = 0; i < 4; i++) stock_m[i] = MAXS;

        tick();
        check("rst_seg_en", int'(seg_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_back", int'(back), 0);
        check("rst_vend_done", int'(vend_done), 0);
        check("rst_remain", int'(pay_remain), 0);
        check("rst_quant", int'(quant), MAXS);
        rst = 1'b1;
        tick();
        check("post_seg_en", int'(seg_en), 1);
        check("post_quant", int'(quant), MAXS);
        check("post_max_add", int'(max_add), 0);
        check("post_remain", int'(pay_remain), 0);
        check("post_back", int'(back), 0);

        script_q = '{2, 2, 2};
        purchase(1, 0);
        script_q = '{3};
        purchase(0, 0);
        script_q = '{2, 5};
        purchase(3, 0);

        script_q = '{3, 3, 3};
        purchase(2, 0);
        script_q = '{3, 3, 3};
        purchase(2, 0);
        restock(2, 9, 0);

        while (stock_m[0] > 0) begin
            script_q = '{3};
            purchase(0, 0);
        end
        purchase(0, 1);
        restock(0, 5, 1);
        restock(1, 3, 1);

        for (int n = 0; n < 30; n++) begin
            int p;
            p = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) restock(p, $urandom_range(0, 15), $urandom_range(0, 1));
            purchase(p, 1);
        end

        // Reset in the middle of a purchase drops the paid amount without refund.
        restock(1, 15, 0);
        prod_sel = 2'd1;
        buy_req  = 1'b1;
        tick();
        buy_req = 1'b0;
        coin_2  = 1'b1;
        tick();
        coin_2 = 1'b0;
        check("midpay_remain", int'(pay_remain), 3);
        rst = 1'b0;
        tick();
        check("midrst_busy", int'(busy), 0);
        check("midrst_seg_en", int'(seg_en), 0);
        check("midrst_remain", int'(pay_remain), 0);
        check("midrst_back", int'(back), 0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) stock_m[i] = MAXS;
        tick();
        check("midrst_after_seg_en", int'(seg_en), 1);
        check("midrst_after_busy", int'(busy), 0);
        check("midrst_after_quant", int'(quant), MAXS);

`ifdef VEND_TIMEOUT_EN
        prod_sel = 2'd1;
        buy_req  = 1'b1;
        tick();
        buy_req = 1'b0;
        coin_1  = 1'b1;
        tick();
        coin_1 = 1'b0;
        for (int k = 0; k < TO_CYC - 1; k++) begin
            check("to_wait_busy", int'(busy), 1);
            check("to_wait_remain", int'(pay_remain), 4);
            tick();
        end
        tick();
        hold_phase(1, 1, 0);
        prod_sel = 2'd3;
        buy_req  = 1'b1;
        tick();
        buy_req = 1'b0;
        rst     = 1'b0;
        tick();
        check("to_rst_busy", int'(busy), 0);
        rst = 1'b1;
        tick();
        check("to_rst_after_busy", int'(busy), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
